// File: rtl/dir_history_display.sv
// Direction-pad front end: synchronise, debounce and edge-detect five buttons, keep a
// NUM_DIGITS-deep glyph history and scan it onto a common-anode 7-segment bank.
// Optional auto-repeat while a single button is held: define DIR_REPEAT_EN.
module dir_history_display #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCAN_CYCLES     = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l,
    input  logic                  c,
    input  logic                  d,
    input  logic                  u,
    input  logic                  r,
    output logic [NUM_DIGITS-1:0] digit,
    output logic [7:0]            seg,
    output logic                  press_valid,
    output logic [2:0]            press_code,
    output logic [7:0]            press_count
);

    localparam int NB    = 5;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef logic [7:0] glyph_t;
    localparam glyph_t GLYPH_BLANK = 8'b11111111;

    function automatic glyph_t f_glyph(input logic [2:0] code);
        case (code)
            3'd0:    f_glyph = 8'b11100011;
            3'd1:    f_glyph = 8'b01100011;
            3'd2:    f_glyph = 8'b10000101;
            3'd3:    f_glyph = 8'b10000011;
            3'd4:    f_glyph = 8'b11110101;
            default: f_glyph = GLYPH_BLANK;
        endcase
    endfunction

    // Bit position equals the press code: L=0, C=1, D=2, U=3, R=4.
    logic [NB-1:0] w_raw;
    assign w_raw = {r, u, d, c, l};

    logic [NB-1:0] r_sync1, r_sync2, r_db, r_db_prev, r_evt;
    logic [DB_W-1:0] r_db_cnt [NB];
    logic [NB-1:0] w_rep_evt;

`ifdef DIR_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    logic [RP_W-1:0] r_rep_cnt;
    logic            r_rep_periodic;
    logic            w_single;
    logic            w_rep_hit;
    logic [RP_W-1:0] w_rep_limit;

    assign w_single    = ($countones(r_db) == 1);
    assign w_rep_limit = r_rep_periodic ? RP_W'(REPEAT_PERIOD) : RP_W'(REPEAT_DELAY);
    assign w_rep_hit   = w_single && (r_rep_cnt == w_rep_limit);
    assign w_rep_evt   = w_rep_hit ? r_db : '0;

    // Timer holds the number of clocks the single button has been held in this phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt      <= '0;
            r_rep_periodic <= 1'b0;
        end else if (!w_single) begin
            r_rep_cnt      <= '0;
            r_rep_periodic <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_cnt      <= RP_W'(1);
            r_rep_periodic <= 1'b1;
        end else begin
            r_rep_cnt      <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_evt = '0;
`endif

    // NOTE: every flop here uses <=, so r_db_prev and r_evt see the pre-edge r_db.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            r_evt     <= '0;
            for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            r_evt     <= (r_db & ~r_db_prev) | w_rep_evt;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]     <= ~r_db[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic       w_accept;
    logic [2:0] w_evt_code;

    assign w_accept = ($countones(r_evt) == 1);

    // NOTE: default first so the encoder cannot infer a latch.
    always_comb begin
        w_evt_code = '0;
        for (int i = 0; i < NB; i++) begin
            if (r_evt[i]) w_evt_code = 3'(i);
        end
    end

    glyph_t r_hist [NUM_DIGITS];

    // NOTE: the history array is reset because a blank display after reset is visible behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_valid <= 1'b0;
            press_code  <= '0;
            press_count <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) r_hist[k] <= GLYPH_BLANK;
        end else begin
            press_valid <= w_accept;
            if (w_accept) begin
                press_code  <= w_evt_code;
                press_count <= press_count + 1'b1;
                for (int k = NUM_DIGITS - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
                r_hist[0] <= f_glyph(w_evt_code);
            end
        end
    end

    logic [SC_W-1:0]  r_scan_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_scan_wrap;
    logic [IDX_W-1:0] w_idx_next;

    assign w_scan_wrap = (r_scan_cnt == SC_W'(SCAN_CYCLES - 1));
    assign w_idx_next  = !w_scan_wrap                        ? r_idx :
                         (r_idx == IDX_W'(NUM_DIGITS - 1))   ? '0    : r_idx + 1'b1;

    // digit and seg are both loaded from the next index so they switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            digit      <= ~NUM_DIGITS'(1);
            seg        <= GLYPH_BLANK;
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            r_idx      <= w_idx_next;
            digit      <= ~(NUM_DIGITS'(1) << w_idx_next);
            seg        <= r_hist[w_idx_next];
        end
    end

endmodule

// File: tb/tb_dir_history_display.sv
// Self-checking bench for dir_history_display: table-driven press vectors, a press scoreboard
// and hand-written latency, simultaneous-press, auto-repeat and mid-debounce reset sequences.
module tb_dir_history_display;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          l = 1'b0, c = 1'b0, d = 1'b0, u = 1'b0, r = 1'b0;
    logic [ND-1:0] digit;
    logic [7:0]    seg;
    logic          press_valid;
    logic [2:0]    press_code;
    logic [7:0]    press_count;

    always #5 clk = ~clk;

    dir_history_display #(
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (4),
        .SCAN_CYCLES     (2),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .l           (l),
        .c           (c),
        .d           (d),
        .u           (u),
        .r           (r),
        .digit       (digit),
        .seg         (seg),
        .press_valid (press_valid),
        .press_code  (press_code),
        .press_count (press_count)
    );

    localparam logic [4:0] B_L = 5'b00001, B_C = 5'b00010, B_D = 5'b00100,
                           B_U = 5'b01000, B_R = 5'b10000;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] code;
        logic [7:0] count;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0] btn;
        int         hold;
        int         gap;
        bit         expect_evt;
        logic [2:0] code;
    } vec_t;
    vec_t vecs [8];

    logic [7:0] exp_count = 8'd0;
    logic [7:0] exp_hist [ND];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] glyph_of(input logic [2:0] code);
        case (code)
            3'd0:    glyph_of = 8'b11100011;
            3'd1:    glyph_of = 8'b01100011;
            3'd2:    glyph_of = 8'b10000101;
            3'd3:    glyph_of = 8'b10000011;
            3'd4:    glyph_of = 8'b11110101;
            default: glyph_of = 8'b11111111;
        endcase
    endfunction

    task automatic set_btn(input logic [4:0] b);
        {r, u, d, c, l} = b;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_evt(input logic [2:0] code);
        sb_t e;
        exp_count = exp_count + 8'd1;
        e.code  = code;
        e.count = exp_count;
        sb_q.push_back(e);
        for (int k = ND - 1; k > 0; k--) exp_hist[k] = exp_hist[k-1];
        exp_hist[0] = glyph_of(code);
    endtask

    task automatic clear_model();
        sb_q.delete();
        exp_count = 8'd0;
        for (int k = 0; k < ND; k++) exp_hist[k] = 8'hFF;
    endtask

    task automatic read_display(input string tag);
        logic [ND-1:0] want;
        bit            found;
        for (int i = 0; i < ND; i++) begin
            want  = ~(ND'(1) << i);
            found = 1'b0;
            for (int cyc = 0; cyc < 40 && !found; cyc++) begin
                @(posedge clk);
                #1;
                if (digit === want) found = 1'b1;
            end
            check($sformatf("%s_digit%0d_seen", tag, i), 32'(found), 32'd1);
            if (found) check($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(exp_hist[i]));
        end
    endtask

    task automatic flush();
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Press monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (press_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_press", 32'(press_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("press_code", 32'(press_code), 32'(e.code));
                    check("press_count", 32'(press_count), 32'(e.count));
                end
            end
        end
    end

    initial begin
        logic [ND-1:0] want;

        clear_model();
        vecs[0] = '{B_L, 3, 3, 1'b0, 3'd0};
        vecs[1] = '{B_L, 3, 3, 1'b0, 3'd0};
        vecs[2] = '{B_L, 3, 3, 1'b0, 3'd0};
        vecs[3] = '{B_L, 10, 10, 1'b1, 3'd0};
        vecs[4] = '{B_D, 10, 10, 1'b1, 3'd2};
        vecs[5] = '{B_R, 10, 10, 1'b1, 3'd4};
        vecs[6] = '{B_C, 10, 10, 1'b1, 3'd1};
        vecs[7] = '{B_U, 10, 10, 1'b1, 3'd3};

        // Reset state
        set_btn(5'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_digit", 32'(digit), 32'b1110);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_press_valid", 32'(press_valid), 32'd0);
        check("rst_press_code", 32'(press_code), 32'd0);
        check("rst_press_count", 32'(press_count), 32'd0);

        // Idle scan: index advances every 2 clocks, one digit low at a time
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            want = ~(ND'(1) << ((k / 2) % ND));
            check($sformatf("scan_digit_k%0d", k), 32'(digit), 32'(want));
            check($sformatf("scan_seg_k%0d", k), 32'(seg), 32'hFF);
        end
        check("idle_press_count", 32'(press_count), 32'd0);

        // Latency: raw u first sampled at edge 0, pulse only in the cycle after edge 7
        @(negedge clk);
        set_btn(B_U);
        push_evt(3'd3);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k >= 6) check($sformatf("latency_edge%0d", k), 32'(press_valid), 32'(k == 7));
        end
        wait_neg(4);
        set_btn(5'b0);
        wait_neg(12);
        flush();
        read_display("after_u");

        // Glitches (no event) then the l,d,r,c,u sequence
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            set_btn(vecs[v].btn);
            if (vecs[v].expect_evt) push_evt(vecs[v].code);
            wait_neg(vecs[v].hold);
            set_btn(5'b0);
            wait_neg(vecs[v].gap);
            if (v == 2) read_display("after_glitch");
        end
        flush();
        read_display("after_seq");

        // Simultaneous l+r ignored; later single l accepted while r held
        @(negedge clk);
        set_btn(B_L | B_R);
        wait_neg(12);
        set_btn(B_R);
        wait_neg(10);
        set_btn(B_L | B_R);
        push_evt(3'd0);
        wait_neg(12);
        set_btn(5'b0);
        wait_neg(12);
        flush();
        read_display("after_simul");

        // Long hold of d: one press, plus repeats when the feature is built in
        @(negedge clk);
        set_btn(B_D);
        push_evt(3'd2);
`ifdef DIR_REPEAT_EN
        repeat (4) push_evt(3'd2);
`endif
        wait_neg(50);
        set_btn(5'b0);
        wait_neg(15);
        flush();
        read_display("after_hold");

        // Reset in the middle of debouncing c
        @(negedge clk);
        set_btn(B_C);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        check("midrst_digit", 32'(digit), 32'b1110);
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_press_valid", 32'(press_valid), 32'd0);
        check("midrst_press_code", 32'(press_code), 32'd0);
        check("midrst_press_count", 32'(press_count), 32'd0);
        wait_neg(2);
        rst = 1'b0;
        wait_neg(2);
        set_btn(5'b0);
        wait_neg(20);
        check("post_rst_press_count", 32'(press_count), 32'd0);
        read_display("after_rst");

        @(negedge clk);
        set_btn(B_C);
        push_evt(3'd1);
        wait_neg(12);
        set_btn(5'b0);
        wait_neg(12);
        flush();
        read_display("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
